// File: rtl/multicore_ctrl_pkg.sv
// Shared types and default widths for the multicore run controller.
package multicore_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

   localparam int unsigned DefNCores = 4;
   localparam int unsigned DefAddrW  = 12;
   localparam int unsigned DefDataW  = 12;
   localparam int unsigned DefCntW   = 16;

endpackage

// File: rtl/multicore_ctrl_if.sv
// Core-side control/access signals and the shared data-memory port of the run controller.
interface multicore_ctrl_if
   import multicore_ctrl_pkg::*;
#(
   parameter int unsigned N_CORES = DefNCores,
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned CNT_W   = DefCntW
);
   logic                        start;
   logic [N_CORES-1:0]          core_mask;
   logic [N_CORES-1:0]          core_start;
   logic [N_CORES-1:0]          core_end;
   logic [N_CORES-1:0]          core_req;
   logic [N_CORES-1:0]          core_we;
   logic [N_CORES*ADDR_W-1:0]   core_addr;
   logic [N_CORES*DATA_W-1:0]   core_wdata;
   logic [N_CORES-1:0]          core_gnt;
   logic [N_CORES-1:0]          core_rvalid;
   logic [DATA_W-1:0]           core_rdata;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_wdata;
   logic                        mem_we;
   logic                        mem_re;
   logic [DATA_W-1:0]           mem_rdata;
   logic                        busy;
   logic                        done;
   logic [CNT_W-1:0]            run_cycles;

   // Environment side: cores, launcher and memory.
   modport master (
      output start, core_mask, core_end, core_req, core_we, core_addr, core_wdata, mem_rdata,
      input  core_start, core_gnt, core_rvalid, core_rdata, mem_addr, mem_wdata, mem_we, mem_re,
             busy, done, run_cycles
   );

   // Controller side.
   modport slave (
      input  start, core_mask, core_end, core_req, core_we, core_addr, core_wdata, mem_rdata,
      output core_start, core_gnt, core_rvalid, core_rdata, mem_addr, mem_wdata, mem_we, mem_re,
             busy, done, run_cycles
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index, pointer resets to 0.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   input  logic         advance_i,
   output logic [N-1:0] gnt_o
);
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] gnt_idx;
   logic [IdxW-1:0] cand;
   logic            found;

   always_comb begin
      gnt_o   = '0;
      gnt_idx = ptr_q;
      cand    = ptr_q;
      found   = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IdxW'((32'(ptr_q) + k) % N);
         if (!found && req_i[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      if (found) begin
         gnt_o[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i && found) begin
         ptr_d = (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/multicore_ctrl.sv
// Launches a set of cores, arbitrates their data-memory accesses and tracks run completion.
module multicore_ctrl
   import multicore_ctrl_pkg::*;
#(
   parameter int unsigned N_CORES = DefNCores,
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned DATA_W  = DefDataW,
   parameter int unsigned CNT_W   = DefCntW
) (
   input  logic             clk,
   input  logic             rst,
   multicore_ctrl_if.slave  bus
);
   state_e state_q, state_d;

   logic [N_CORES-1:0] act_mask_q, act_mask_d;
   logic [N_CORES-1:0] end_seen_q, end_seen_d;
   logic [N_CORES-1:0] gnt_q, gnt_d;
   logic [N_CORES-1:0] rvalid_q, rvalid_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
   logic               mem_we_q, mem_we_d;
   logic               mem_re_q, mem_re_d;
   logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;

   logic               launch, all_ended, busy;
   logic [N_CORES-1:0] eligible, arb_gnt;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               sel_we;

   assign launch    = ((state_q == StIdle) || (state_q == StDone)) && bus.start
                      && (bus.core_mask != '0);
   assign all_ended = ((end_seen_q | bus.core_end) & act_mask_q) == act_mask_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: if (launch)    state_d = StRun;
         StRun:          if (all_ended) state_d = StDrain;
         StDrain:        if (!mem_re_q) state_d = StDone;
         default:                       state_d = StIdle;
      endcase
   end

   always_comb begin
      busy            = (state_q == StRun) || (state_q == StDrain);
      bus.busy        = busy;
      bus.done        = (state_q == StDone);
      bus.core_start  = busy ? act_mask_q : '0;
      bus.core_gnt    = gnt_q;
      bus.core_rvalid = rvalid_q;
      bus.core_rdata  = (rvalid_q != '0) ? bus.mem_rdata : '0;
      bus.mem_addr    = mem_addr_q;
      bus.mem_wdata   = mem_wdata_q;
      bus.mem_we      = mem_we_q;
      bus.mem_re      = mem_re_q;
      bus.run_cycles  = run_cycles_q;
   end

   // A core that ends this cycle, or was granted last cycle, does not compete.
   assign eligible = (state_q == StRun) ?
                     (bus.core_req & act_mask_q & ~end_seen_q & ~bus.core_end & ~gnt_q) : '0;

   rr_arbiter #(
      .N (N_CORES)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_i     (eligible),
      .advance_i (|eligible),
      .gnt_o     (arb_gnt)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int i = 0; i < int'(N_CORES); i++) begin
         if (arb_gnt[i]) begin
            sel_addr  = bus.core_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = bus.core_wdata[i*DATA_W +: DATA_W];
            sel_we    = bus.core_we[i];
         end
      end
   end

   always_comb begin
      act_mask_d  = launch ? bus.core_mask : act_mask_q;
      end_seen_d  = end_seen_q;
      if (launch) begin
         end_seen_d = '0;
      end else if (state_q == StRun) begin
         end_seen_d = end_seen_q | (bus.core_end & act_mask_q);
      end
      gnt_d       = arb_gnt;
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_wdata;
      mem_we_d    = sel_we;
      mem_re_d    = (arb_gnt != '0) && !sel_we;
      // Read data arrives one cycle after the command, so rvalid trails the grant by one.
      rvalid_d    = mem_re_q ? gnt_q : '0;
      run_cycles_d = run_cycles_q;
      if (launch) begin
         run_cycles_d = '0;
      end else if (busy && (run_cycles_q != {CNT_W{1'b1}})) begin
         run_cycles_d = run_cycles_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_mask_q   <= '0;
         end_seen_q   <= '0;
         gnt_q        <= '0;
         rvalid_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         run_cycles_q <= '0;
      end else begin
         act_mask_q   <= act_mask_d;
         end_seen_q   <= end_seen_d;
         gnt_q        <= gnt_d;
         rvalid_q     <= rvalid_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
         run_cycles_q <= run_cycles_d;
      end
   end

endmodule

// File: doc/multicore_ctrl.md
MULTICORE_CTRL -- requirements
Module: multicore_ctrl

Interface
REQ-001 Parameter N_CORES, default 4, number of attached processor cores (2..8).
REQ-002 Parameter ADDR_W, default 12, data-memory address width.
REQ-003 Parameter DATA_W, default 12, data-memory word width.
REQ-004 Parameter CNT_W, default 16, run-cycle counter width.
REQ-005 Ports: clk in 1, the single clock; rst in 1, reset, synchronous, active-high.
REQ-006 start in 1 (launch pulse); core_mask in N_CORES (cores taking part, sampled at launch).
REQ-007 core_start out N_CORES (per-core start_process); core_end in N_CORES (per-core end_process).
REQ-008 core_req in N_CORES (access request); core_we in N_CORES (1 = write, 0 = read).
REQ-009 core_addr in N_CORES*ADDR_W; core_wdata in N_CORES*DATA_W (core i at slice [i*W +: W]).
REQ-010 core_gnt out N_CORES (one-hot grant); core_rvalid out N_CORES (read data valid); core_rdata out DATA_W (shared).
REQ-011 mem_addr out ADDR_W; mem_wdata out DATA_W; mem_we out 1; mem_re out 1; mem_rdata in DATA_W (one-cycle read latency).
REQ-012 busy out 1; done out 1; run_cycles out CNT_W.

Function
REQ-013 FSM states IDLE, RUN, DRAIN, DONE shall be used.
REQ-014 IDLE: start=1 shall latch core_mask into act_mask and go to RUN next cycle; start with core_mask=0 shall be ignored.
REQ-015 RUN/DRAIN: core_start shall equal act_mask (registered, held high); in IDLE/DONE, core_start=0.
REQ-016 core_end[i] shall be captured into a sticky end_seen[i], cleared on launch; core_end from unmasked cores shall be ignored.
REQ-017 RUN -> DRAIN when (end_seen | core_end) & act_mask == act_mask.
REQ-018 DRAIN -> DONE when no read is in flight; otherwise wait one cycle.
REQ-019 DONE: done=1 held; start=1 in DONE shall relaunch exactly as from IDLE.
REQ-020 busy shall be 1 in RUN and DRAIN only.
REQ-021 Arbitration in RUN only: eligible = core_req & act_mask & ~end_seen; round-robin, priority starting at last-granted+1 (mod N_CORES), pointer initially at core 0 after reset.
REQ-022 At most one grant per cycle; a request visible at cycle t shall see core_gnt and the memory command (mem_addr/mem_wdata/mem_we/mem_re) registered at t+1.
REQ-023 Grant at t+1 for a read shall produce core_rvalid[i]=1 with core_rdata=mem_rdata at t+2, single cycle.
REQ-024 A core shall hold core_req/addr/data until it sees core_gnt; a core granted at t+1 shall not be granted again at t+1's arbitration (one-cycle ineligibility).
REQ-025 mem_we and mem_re shall never both be 1; both 0 when no grant.
REQ-026 run_cycles shall clear on launch, increment every RUN/DRAIN cycle, and saturate at all-ones.
REQ-027 Simultaneous core_end[i] and core_req[i] in same cycle: request is dropped, end wins.

Reset
REQ-028 rst shall force IDLE; core_start, core_gnt, core_rvalid, mem_we, mem_re, busy, done = 0; core_rdata, mem_addr, mem_wdata, run_cycles = 0; act_mask, end_seen = 0; RR pointer = 0.
REQ-029 rst asserted mid-RUN shall abort immediately; an in-flight read's core_rvalid shall not be emitted.

Structure
REQ-030 State encoding and default widths (12-bit address/data) shall live in the shared project package.
REQ-031 The round-robin arbiter shall be one sub-module, rr_arbiter (parameter N, req in, gnt one-hot out, advance in).

Verification
REQ-032 Launch mask=4'b0101, start pulse -> next cycle core_start=4'b0101, busy=1; mask 0 start -> stays IDLE.
REQ-033 Cores 0,1,2,3 all request reads continuously -> grants rotate 0,1,2,3,0; each core_rvalid two cycles after its request visible; mem_rdata returned to correct core.
REQ-034 Core 2 write addr 0x01A data 0x5C3 -> mem_we=1, mem_addr=0x01A, mem_wdata=0x5C3 one cycle after request; no rvalid.
REQ-035 Mask 4'b0011: core 1 ends, core 0 ends with a read granted same cycle -> DRAIN one cycle, rvalid to core 0, then DONE, done=1, run_cycles = cycles from launch.
REQ-036 rst during RUN with read in flight -> all outputs reset values next cycle, no rvalid; start then relaunches normally.
REQ-037 Hold RUN 2^CNT_W+5 cycles (CNT_W=4 build) -> run_cycles saturates at 15.
